// File: rtl/ahb_lite_master_ctrl.sv
// AHB-Lite master front-end: arbitrates fetch/data ports onto one non-pipelined bus.
// Optional data-phase watchdog (with timeout_flag port) enabled by defining AHBM_TIMEOUT_EN.
module ahb_lite_master_ctrl #(
    parameter int          ADDR_W      = 32,
    parameter logic [3:0]  HPROT_INSTR = 4'b0000,
    parameter logic [3:0]  HPROT_DATA  = 4'b0001,
    parameter int          TIMEOUT_CYC = 256
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_fn3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [3:0]        hprot,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready,
    input  logic              hresp
`ifdef AHBM_TIMEOUT_EN
    ,
    output logic              timeout_flag
`endif
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR2, S_RESP} state_t;

    state_t      state;
    logic        sel_d;
    logic        we_q;
    logic [2:0]  fn3_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    // B for fn3[1:0]=00, H for 01, everything else (W and undefined codes) is a word
    function automatic logic [2:0] fn3_size(input logic [2:0] fn3);
        case (fn3[1:0])
            2'b00:   fn3_size = 3'b000;
            2'b01:   fn3_size = 3'b001;
            default: fn3_size = 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [2:0] size, input logic [31:0] w);
        case (size)
            3'b000:  lane_rep = {4{w[7:0]}};
            3'b001:  lane_rep = {2{w[15:0]}};
            default: lane_rep = w;
        endcase
    endfunction

    function automatic logic [31:0] rd_extract(input logic [2:0] fn3, input logic [1:0] a,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (fn3)
            3'b000:  rd_extract = {{24{b[7]}}, b};
            3'b001:  rd_extract = {{16{h[15]}}, h};
            3'b100:  rd_extract = {24'h0, b};
            3'b101:  rd_extract = {16'h0, h};
            default: rd_extract = rd;
        endcase
    endfunction

    logic              any_req;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_fn3;
    logic [2:0]        req_size;
    logic              req_misal;
    logic              launch;
    logic              tgt_d;
    logic              fin;
    logic              fin_err;
    logic              tmo_hit;

    assign any_req  = d_req | if_req;
    assign req_addr = d_req ? d_addr : if_addr;
    assign req_fn3  = d_req ? d_fn3 : 3'b010;
    assign req_size = fn3_size(req_fn3);
    assign req_misal = (req_size == 3'b001) ? req_addr[0] :
                       (req_size == 3'b010) ? (|req_addr[1:0]) : 1'b0;
    assign launch   = (state == S_IDLE) && any_req && !req_misal;
    // in IDLE the winner is not latched yet, so route a misalignment error directly
    assign tgt_d    = (state == S_IDLE) ? d_req : sel_d;

`ifdef AHBM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             busy;

    assign busy    = (state == S_ADDR) || (state == S_DATA) || (state == S_ERR2);
    assign tmo_hit = busy && !hready && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (launch)
                tmo_cnt <= '0;
            else if (busy && !hready)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit)
                timeout_flag <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // transfer completion this cycle, and whether it completes with an error
    always_comb begin
        fin     = 1'b0;
        fin_err = 1'b0;
        case (state)
            S_IDLE: if (any_req && req_misal) begin fin = 1'b1; fin_err = 1'b1; end
            S_DATA: if (hready)               begin fin = 1'b1; fin_err = hresp; end
            S_ERR2: if (hready)               begin fin = 1'b1; fin_err = 1'b1;  end
            default: ;
        endcase
        if (tmo_hit) begin
            fin     = 1'b1;
            fin_err = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= S_IDLE;
            sel_d    <= 1'b0;
            we_q     <= 1'b0;
            fn3_q    <= 3'b010;
            lane_q   <= 2'b00;
            wdata_q  <= '0;
            haddr    <= '0;
            htrans   <= TR_IDLE;
            hwrite   <= 1'b0;
            hsize    <= 3'b010;
            hprot    <= 4'b0000;
            hwdata   <= '0;
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            if_err <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (launch) begin
                        sel_d   <= d_req;
                        we_q    <= d_req & d_we;
                        fn3_q   <= req_fn3;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= d_wdata;
                        haddr   <= req_addr;
                        htrans  <= TR_NONSEQ;
                        hwrite  <= d_req & d_we;
                        hsize   <= req_size;
                        hprot   <= d_req ? HPROT_DATA : HPROT_INSTR;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        htrans <= TR_IDLE;
                        hwdata <= lane_rep(hsize, wdata_q);
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (hready && !hresp) begin
                        if (sel_d) begin
                            if (!we_q)
                                d_rdata <= rd_extract(fn3_q, lane_q, hrdata);
                        end else begin
                            if_rdata <= hrdata;
                        end
                    end else if (!hready && hresp) begin
                        state <= S_ERR2;
                    end
                end
                S_ERR2: ;
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // every completion path (including watchdog abort) funnels through RESP
            if (fin) begin
                state  <= S_RESP;
                htrans <= TR_IDLE;
                d_ack  <=  tgt_d & !fin_err;
                d_err  <=  tgt_d &  fin_err;
                if_ack <= !tgt_d & !fin_err;
                if_err <= !tgt_d &  fin_err;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_ctrl.sv
// Directed bench for ahb_lite_master_ctrl: scripted AHB slave responses with a response scoreboard.
module tb_ahb_lite_master_ctrl;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        if_req, if_ack, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [2:0]  d_fn3;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
`ifdef AHBM_TIMEOUT_EN
    logic        timeout_flag;
`endif

    ahb_lite_master_ctrl dut (
        .hclk(hclk), .hresetn(hresetn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_fn3(d_fn3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
`ifdef AHBM_TIMEOUT_EN
        , .timeout_flag(timeout_flag)
`endif
    );

    always #5 hclk = ~hclk;

    typedef struct {
        bit          dside;
        bit          err;
        logic [31:0] rdata;
        int          lat;
    } resp_t;

    resp_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_d  = 32'h0;
    logic [31:0] last_if = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One transfer: drive request, act as slave, pop and compare the response pulse.
    task automatic xfer(input bit dside, input bit we, input logic [2:0] fn3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input bit err,
                        input bit misal, input logic [2:0] exp_size,
                        input logic [31:0] exp_hw, input logic [31:0] exp_rd,
                        input bit hold_if, input string tag);
        resp_t r, g;
        int    cyc, dcnt;
        bit    saw_addr, in_data, done, e1;
        @(negedge hclk);
        if (dside) begin
            d_req = 1'b1; d_we = we; d_fn3 = fn3; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        if (hold_if) begin
            if_req = 1'b1; if_addr = 32'hA000_0008;
        end
        r.dside = dside;
        r.err   = err | misal;
        if (err || misal || we)
            r.rdata = dside ? last_d : last_if;
        else
            r.rdata = exp_rd;
        r.lat = misal ? 1 : 3 + waits + (err ? 1 : 0);
        if (!r.err && !we) begin
            if (dside) last_d = exp_rd; else last_if = exp_rd;
        end
        sb.push_back(r);

        cyc = 0; dcnt = 0; saw_addr = 0; in_data = 0; done = 0; e1 = 0;
        while (!done && cyc < 50) begin
            @(negedge hclk);
            cyc++;
            if (if_ack || if_err || d_ack || d_err) begin
                g = sb.pop_front();
                chk({tag, ".side"},  {31'h0, d_ack | d_err}, {31'h0, g.dside});
                chk({tag, ".err"},   {31'h0, if_err | d_err}, {31'h0, g.err});
                chk({tag, ".one"},   32'(int'(if_ack) + int'(if_err) + int'(d_ack) + int'(d_err)), 32'd1);
                chk({tag, ".rdata"}, (d_ack | d_err) ? d_rdata : if_rdata, g.rdata);
                chk({tag, ".lat"},   32'(cyc), 32'(g.lat));
                if (dside) d_req = 1'b0; else if_req = 1'b0;
                hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
                done = 1;
            end else if (htrans == 2'b10 && !saw_addr) begin
                saw_addr = 1;
                chk({tag, ".haddr"},  haddr, addr);
                chk({tag, ".hsize"},  {29'h0, hsize}, {29'h0, exp_size});
                chk({tag, ".hwrite"}, {31'h0, hwrite}, {31'h0, we});
                chk({tag, ".hprot"},  {28'h0, hprot}, dside ? 32'h1 : 32'h0);
                in_data = 1;
            end else if (in_data) begin
                if (dcnt == 0 && we) chk({tag, ".hwdata"}, hwdata, exp_hw);
                if (dcnt < waits) begin
                    hready = 1'b0; hresp = 1'b0;
                end else if (err && !e1) begin
                    hready = 1'b0; hresp = 1'b1; e1 = 1;
                end else if (err) begin
                    hready = 1'b1; hresp = 1'b1;
                end else begin
                    hready = 1'b1; hresp = 1'b0; hrdata = rdata;
                end
                dcnt++;
            end
        end
        if (!done) begin
            chk({tag, ".timeout"}, 32'h0, 32'h1);
            void'(sb.pop_front());
            d_req = 1'b0; if_req = 1'b0; hready = 1'b1; hresp = 1'b0;
        end
        chk({tag, ".bus_used"}, {31'h0, saw_addr}, {31'h0, !misal});
    endtask

    initial begin
        int pulses;
        hresetn = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_fn3 = 3'b010; d_addr = '0; d_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        chk("rst.htrans", {30'h0, htrans}, 32'h0);
        chk("rst.haddr",  haddr, 32'h0);
        chk("rst.hsize",  {29'h0, hsize}, 32'h2);
        chk("rst.hprot",  {28'h0, hprot}, 32'h0);
        chk("rst.hwrite", {31'h0, hwrite}, 32'h0);
        chk("rst.hwdata", hwdata, 32'h0);
        chk("rst.pulses", {28'h0, if_ack, if_err, d_ack, d_err}, 32'h0);
        chk("rst.rdata",  if_rdata | d_rdata, 32'h0);
        hresetn = 1'b1;

        //   dside we fn3 addr wdata hrdata waits err misal size hwdata exp_rd hold tag
        xfer(0, 0, 3'b010, 32'hA000_0004, 32'h0, 32'h0050_0093, 0, 0, 0, 3'b010, 32'h0, 32'h0050_0093, 0, "fetch");
        xfer(1, 0, 3'b000, 32'hB000_0003, 32'h0, 32'h80FF_FFFF, 0, 0, 0, 3'b000, 32'h0, 32'hFFFF_FF80, 0, "lb");
        xfer(1, 0, 3'b100, 32'hB000_0003, 32'h0, 32'h80FF_FFFF, 0, 0, 0, 3'b000, 32'h0, 32'h0000_0080, 0, "lbu");
        xfer(1, 1, 3'b001, 32'hB000_0002, 32'h1234_ABCD, 32'h0, 2, 0, 0, 3'b001, 32'hABCD_ABCD, 32'h0, 0, "sh_wait");
        xfer(1, 0, 3'b010, 32'hB000_0008, 32'h0, 32'h5555_5555, 1, 1, 0, 3'b010, 32'h0, 32'h0, 0, "lw_hresp");
        xfer(1, 0, 3'b001, 32'hB000_0006, 32'h0, 32'h8001_7FFF, 0, 0, 0, 3'b001, 32'h0, 32'hFFFF_8001, 1, "cont_lh");
        xfer(0, 0, 3'b010, 32'hA000_0008, 32'h0, 32'h1234_5678, 0, 0, 0, 3'b010, 32'h0, 32'h1234_5678, 0, "cont_if");
        xfer(1, 0, 3'b010, 32'hB000_0001, 32'h0, 32'h0, 0, 0, 1, 3'b010, 32'h0, 32'h0, 0, "lw_misal");
        xfer(0, 0, 3'b010, 32'hA000_0002, 32'h0, 32'h0, 0, 0, 1, 3'b010, 32'h0, 32'h0, 0, "if_misal");
        xfer(1, 1, 3'b001, 32'hB000_0003, 32'h0000_BEEF, 32'h0, 0, 0, 1, 3'b001, 32'h0, 32'h0, 0, "sh_misal");
        xfer(1, 1, 3'b000, 32'hB000_0001, 32'h1234_56A5, 32'h0, 0, 0, 0, 3'b000, 32'hA5A5_A5A5, 32'h0, 0, "sb");
        xfer(1, 0, 3'b101, 32'hB000_0002, 32'h0, 32'hBEEF_1234, 1, 0, 0, 3'b001, 32'h0, 32'h0000_BEEF, 0, "lhu");
        xfer(1, 0, 3'b011, 32'hB000_000C, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 3'b010, 32'h0, 32'hCAFE_F00D, 0, "lw_undef");

        // asynchronous reset while the data phase is stalled
        @(negedge hclk);
        d_req = 1'b1; d_we = 1'b0; d_fn3 = 3'b010; d_addr = 32'hB000_0010;
        for (int i = 0; i < 10 && htrans != 2'b10; i++) @(negedge hclk);
        chk("rstdata.addr_phase", {30'h0, htrans}, 32'h2);
        @(negedge hclk);
        hready = 1'b0;
        #2 hresetn = 1'b0;
        #1;
        chk("rstdata.htrans", {30'h0, htrans}, 32'h0);
        chk("rstdata.haddr",  haddr, 32'h0);
        chk("rstdata.hsize",  {29'h0, hsize}, 32'h2);
        chk("rstdata.hprot",  {28'h0, hprot}, 32'h0);
        chk("rstdata.hwdata", hwdata, 32'h0);
        chk("rstdata.d_rdata", d_rdata, 32'h0);
        chk("rstdata.if_rdata", if_rdata, 32'h0);
        d_req = 1'b0; hready = 1'b1;
        @(negedge hclk);
        hresetn = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge hclk);
            pulses += int'(if_ack) + int'(if_err) + int'(d_ack) + int'(d_err);
        end
        chk("rstdata.no_ack", 32'(pulses), 32'h0);
        chk("rstdata.idle", {30'h0, htrans}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
